// File: rtl/multdiv.sv
// Multi-cycle signed 32-bit multiply/divide unit for the execute stage.
//
// Multiply is radix-4 Booth over ITER_MUL cycles. Divide is restoring division
// on operand magnitudes over ITER_DIV cycles, followed by one sign-fix cycle.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   data_operandA/B     - two's complement operands, sampled on a start edge only
//   ctrl_MULT/ctrl_DIV  - start requests, honoured only while idle (multiply wins)
//   data_result         - registered result, held until the next completion
//   data_exception      - overflow or divide-by-zero for the last operation
//   data_resultRDY      - one-cycle pulse when result/exception are valid
//   busy                - high from the cycle after a start through the ready cycle
module multdiv #(
    parameter int unsigned ITER_MUL = 16,
    parameter int unsigned ITER_DIV = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    // {acc[31:0], multiplier[31:0], guard}
    logic [64:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic        dz_q, dz_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;

    // Booth step
    logic [33:0] a_ext;
    logic [33:0] addend;
    logic [33:0] booth_sum;
    logic [64:0] prod_step;

    assign a_ext = {{2{mcand_q[31]}}, mcand_q};

    always_comb begin
        addend = '0;
        case (prod_q[2:0])
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_ext << 1;
            3'b100:         addend = -(a_ext << 1);
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
    end

    // 34-bit accumulator absorbs the +-2A headroom; the shift then drops 2 bits.
    assign booth_sum = {{2{prod_q[64]}}, prod_q[64:33]} + addend;
    assign prod_step = {booth_sum, prod_q[32:2]};

    // Restoring divide step
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {1'b0, divisor_q};
    assign rem_step  = diff[32] ? rem_shift[31:0] : diff[31:0];
    assign quo_step  = {quo_q[30:0], ~diff[32]};

    // Operand magnitudes; |0x80000000| is correct when read as unsigned.
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        // Registered so busy stays low in the cycle right after the start edge
        // and drops in the cycle after the ready pulse.
        busy_d    = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);

        case (state_q)
            StIdle: begin
                if (ctrl_MULT) begin
                    state_d = StMul;
                    cnt_d   = '0;
                    mcand_d = data_operandA;
                    prod_d  = {32'b0, data_operandB, 1'b0};
                end else if (ctrl_DIV) begin
                    state_d   = StDiv;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    divisor_d = abs_b;
                    neg_d     = data_operandA[31] ^ data_operandB[31];
                    dz_d      = (data_operandB == 32'h0);
                    ovf_d     = (data_operandA == 32'h8000_0000) &&
                                (data_operandB == 32'hFFFF_FFFF);
                end
            end
            StMul: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_MUL - 1)) begin
                    state_d  = StDone;
                    result_d = prod_step[32:1];
                    // product[63:31] must be a pure sign extension to fit in 32 bits
                    exc_d    = !((&prod_step[64:32]) || !(|prod_step[64:32]));
                    rdy_d    = 1'b1;
                end
            end
            StDiv: begin
                if (dz_q) begin
                    state_d  = StDone;
                    result_d = '0;
                    exc_d    = 1'b1;
                    rdy_d    = 1'b1;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER_DIV - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d  = StDone;
                result_d = neg_q ? -quo_q : quo_q;
                exc_d    = ovf_q;
                rdy_d    = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv.sv
module tb_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv #(
        .ITER_MUL(16),
        .ITER_DIV(32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] last_res;
    logic        last_exc;

    typedef struct {
        bit          do_mul;
        bit          do_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic with the unit's documented special cases.
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output bit e, output int lat);
        longint p;
        int     q;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            lat = 16;
        end else if (b == 32'h0) begin
            r   = 32'h0;
            e   = 1'b1;
            lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r   = 32'h8000_0000;
            e   = 1'b1;
            lat = 33;
        end else begin
            q   = $signed(a) / $signed(b);
            r   = q;
            e   = 1'b0;
            lat = 33;
        end
    endtask

    // Issue one start, then watch busy/ready cycle by cycle.
    // inj > 0 drives a ctrl_DIV pulse during that cycle of the operation.
    task automatic run_op(input bit mul_en, input bit div_en, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input bit ee,
                          input int lat, input string name, input int inj);
        int          got;
        int          busy_err;
        logic [31:0] r_got;
        logic        e_got;
        got      = -1;
        busy_err = 0;
        r_got    = 'x;
        e_got    = 1'bx;
        @(negedge clock);
        ctrl_MULT     = mul_en;
        ctrl_DIV      = div_en;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        chk({name, "/busy_c0"}, {31'b0, busy}, 32'd0);
        chk({name, "/held_c0"}, data_result, last_res);
        chk({name, "/heldexc_c0"}, {31'b0, data_exception}, {31'b0, last_exc});
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1 && got < 0) begin
                got   = k;
                r_got = data_result;
                e_got = data_exception;
            end
            if (k <= lat && busy !== 1'b1) busy_err++;
            if (inj > 0 && k == inj) ctrl_DIV = 1'b1;
            if (inj > 0 && k == inj + 1) ctrl_DIV = 1'b0;
            if (got >= 0 && k == got + 1) begin
                chk({name, "/rdy_after"}, {31'b0, data_resultRDY}, 32'd0);
                chk({name, "/busy_after"}, {31'b0, busy}, 32'd0);
                break;
            end
        end
        ctrl_DIV = 1'b0;
        chk({name, "/latency"}, got, lat);
        chk({name, "/result"}, r_got, er);
        chk({name, "/exc"}, {31'b0, e_got}, {31'b0, ee});
        chk({name, "/busy_win"}, busy_err, 0);
        last_res = er;
        last_exc = ee;
    endtask

    task automatic count_rdy(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) n++;
        end
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        bit          ee;
        int          lat;
        bit          is_div;

        vecs[0] = '{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 16, "mul_7_m3"};
        vecs[1] = '{1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 16, "mul_ovf"};
        vecs[2] = '{1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 16, "mul_min_1"};
        vecs[3] = '{1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 0, 16, "mul_m1_m1"};
        vecs[4] = '{1, 0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1, 16, "mul_min_min"};
        vecs[5] = '{0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 33, "div_m7_2"};
        vecs[6] = '{0, 1, 32'd100,        32'd0,         32'h0000_0000, 1, 1,  "div_by_0"};
        vecs[7] = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 33, "div_min_m1"};
        vecs[8] = '{0, 1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33, "div_7_m2"};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("rst/result", data_result, 32'd0);
        chk("rst/exc", {31'b0, data_exception}, 32'd0);
        chk("rst/rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("rst/busy", {31'b0, busy}, 32'd0);
        reset    = 1'b0;
        last_res = 32'd0;
        last_exc = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].do_mul, vecs[i].do_div, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].exc, vecs[i].lat, vecs[i].name, 0);
        end

        // Both starts together: multiply wins; a divide request mid-flight is dropped.
        run_op(1, 1, 32'd6, 32'd3, 32'd18, 0, 16, "both_start", 5);
        count_rdy(40, n);
        chk("both_start/no_second_rdy", n, 0);
        chk("both_start/result_kept", data_result, 32'd18);

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst/result", data_result, 32'd0);
        chk("async_rst/exc", {31'b0, data_exception}, 32'd0);
        chk("async_rst/rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("async_rst/busy", {31'b0, busy}, 32'd0);
        #1 reset = 1'b0;
        count_rdy(40, n);
        chk("async_rst/no_rdy", n, 0);
        last_res = 32'd0;
        last_exc = 1'b0;
        run_op(1, 0, 32'd2, 32'd2, 32'd4, 0, 16, "post_rst_mul", 0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            is_div = 1'($urandom_range(0, 1));
            a      = $urandom;
            b      = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(0, 15) - 8;
                2: a = $urandom_range(0, 255) - 128;
                default: ;
            endcase
            model(is_div, a, b, er, ee, lat);
            run_op(!is_div, is_div, a, b, er, ee, lat, is_div ? "rnd_div" : "rnd_mul", 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
